// File: rtl/iram_port_arb.sv
// Three-way arbiter for the single-port instruction RAM: debug loader (m0), load/store (m1), fetch (m2).
// Grants one access per cycle, returns 1-cycle read data to its owner, guards fetch against starvation.
module iram_port_arb #(
   parameter int AW         = 15,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic [AW-1:0]     m0_addr,
   input  logic [DW/8-1:0]   m0_we,
   input  logic [DW-1:0]     m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DW-1:0]     m0_rdata,
   input  logic              m0_lock,
   input  logic              m1_req,
   input  logic [AW-1:0]     m1_addr,
   input  logic [DW/8-1:0]   m1_we,
   input  logic [DW-1:0]     m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DW-1:0]     m1_rdata,
   input  logic              m2_req,
   input  logic [AW-1:0]     m2_addr,
   input  logic [DW/8-1:0]   m2_we,
   input  logic [DW-1:0]     m2_wdata,
   output logic              m2_gnt,
   output logic              m2_rvalid,
   output logic [DW-1:0]     m2_rdata,
   output logic              lock_active,
   output logic              ram_en,
   output logic [DW/8-1:0]   ram_we,
   output logic [AW-1:0]     ram_addr,
   output logic [DW-1:0]     ram_wdata,
   input  logic [DW-1:0]     ram_rdata
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

   typedef enum logic {ARB, LOCK} state_t;

   state_t            r_state;
   state_t            w_stateNext;
   logic [SW-1:0]     r_starveCnt;
   logic [2:0]        r_rvalid;
   logic [2:0]        w_gnt;
   logic [DW/8-1:0]   w_we;
   logic              w_starved;
   logic              w_isRead;

   assign w_starved = (r_starveCnt == LIM);

   // LOCK hands the RAM to m0 alone; otherwise m0 first, then m1/m2 swapped once fetch is starved.
   always_comb begin
      w_gnt = '0;
      if (rst_n) begin
         if (r_state == LOCK) begin
            w_gnt[0] = m0_req;
         end else if (m0_req) begin
            w_gnt[0] = 1'b1;
         end else if (w_starved) begin
            if (m2_req)      w_gnt[2] = 1'b1;
            else if (m1_req) w_gnt[1] = 1'b1;
         end else begin
            if (m1_req)      w_gnt[1] = 1'b1;
            else if (m2_req) w_gnt[2] = 1'b1;
         end
      end
   end

   always_comb begin
      ram_addr  = m2_addr;
      ram_wdata = m2_wdata;
      w_we      = m2_we;
      if (w_gnt[0]) begin
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
         w_we      = m0_we;
      end else if (w_gnt[1]) begin
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
         w_we      = m1_we;
      end
      ram_en   = |w_gnt;
      ram_we   = ram_en ? w_we : '0;
      w_isRead = (w_we == '0);
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ARB:     if (w_gnt[0] && m0_lock) w_stateNext = LOCK;
         LOCK:    if (!m0_lock)            w_stateNext = ARB;
         default: w_stateNext = ARB;
      endcase
   end

   // The one-hot r_rvalid doubles as the read-owner record for the returning word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ARB;
         r_starveCnt <= '0;
         r_rvalid    <= '0;
      end else begin
         r_state  <= w_stateNext;
         r_rvalid <= w_gnt & {3{w_isRead}};
         if (r_state == ARB) begin
            if (m2_req && !w_gnt[2]) begin
               if (r_starveCnt != LIM) r_starveCnt <= r_starveCnt + 1'b1;
            end else begin
               r_starveCnt <= '0;
            end
         end
      end
   end

   assign m0_gnt      = w_gnt[0];
   assign m1_gnt      = w_gnt[1];
   assign m2_gnt      = w_gnt[2];
   assign m0_rvalid   = r_rvalid[0] & rst_n;
   assign m1_rvalid   = r_rvalid[1] & rst_n;
   assign m2_rvalid   = r_rvalid[2] & rst_n;
   assign m0_rdata    = ram_rdata;
   assign m1_rdata    = ram_rdata;
   assign m2_rdata    = ram_rdata;
   assign lock_active = (r_state == LOCK);

endmodule
